stream_in_dispatch: RTL and testbench

Parametrised AXI-Stream pixel ingress for the Up-Sampling array. It accepts one pixel per beat from the VDMA stream and tracks column and row internally. Each pixel is broadcast to every one of N_PARALLEL processing elements whose column segment, including a symmetric halo, covers it. Each element is fed through its own small FIFO, so one stalled element only blocks beats it actually needs.

---
 rtl/stream_in_dispatch_pkg.sv | 37 +++
 rtl/stream_in_dispatch_if.sv | 24 ++
 rtl/stream_in_dispatch_fifo.sv | 54 +++++
 rtl/stream_in_dispatch.sv | 157 +++++++++++++++
 tb/tb_stream_in_dispatch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/stream_in_dispatch_pkg.sv
// Shared types, window helpers and width helpers for the stream_in_dispatch slice.
package stream_in_dispatch_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned DEF_DATA_WIDTH     = 32;
   localparam int unsigned DEF_SRC_IMG_WIDTH  = 1920;
   localparam int unsigned DEF_SRC_IMG_HEIGHT = 1080;

   // Width of a counter able to index a dimension; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

   localparam int unsigned DEF_COL_W = clog2_min1(DEF_SRC_IMG_WIDTH);
   localparam int unsigned DEF_ROW_W = clog2_min1(DEF_SRC_IMG_HEIGHT);

   // First column of PE j's segment extended left by the halo, clipped at 0.
   function automatic int unsigned win_start(input int unsigned j, input int unsigned w,
                                             input int unsigned n, input int unsigned halo);
      int unsigned b;
      b = w / n;
      return (j * b >= halo) ? (j * b - halo) : 0;
   endfunction

   // Last column of PE j's segment extended right by the halo, clipped at w-1.
   function automatic int unsigned win_end(input int unsigned j, input int unsigned w,
                                           input int unsigned n, input int unsigned halo);
      int unsigned e;
      e = (j + 1) * (w / n) - 1 + halo;
      return (e > w - 1) ? (w - 1) : e;
   endfunction

endpackage

// File: rtl/stream_in_dispatch_if.sv
// Pixel ingress stream plus the per-PE output channels of stream_in_dispatch.
interface stream_in_dispatch_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned N_PARALLEL = 2
);
   logic                             s_axis_tvalid;
   logic                             s_axis_tready;
   logic [DATA_WIDTH-1:0]            s_axis_tdata;
   logic                             s_axis_tlast;
   logic [N_PARALLEL-1:0]            m_valid;
   logic [N_PARALLEL-1:0]            m_ready;
   logic [N_PARALLEL*DATA_WIDTH-1:0] m_data;
   logic [N_PARALLEL-1:0]            m_last;

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_ready,
      input  s_axis_tready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_ready,
      output s_axis_tready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/stream_in_dispatch_fifo.sv
// Per-PE channel FIFO: count-based full, no push/pop bypass, synchronous flush.
module stream_in_dispatch_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   // Empty channel presents zero so the bus is clean out of reset and after a flush.
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/stream_in_dispatch.sv
// Pixel ingress: tracks col/row and broadcasts each beat to every PE whose haloed segment covers it.
// Optional STREAM_IN_TLAST_CHECK_EN: flags tlast/column mismatches and resyncs col on early tlast.
module stream_in_dispatch
   import stream_in_dispatch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned SRC_IMG_WIDTH  = 1920,
   parameter int unsigned SRC_IMG_HEIGHT = 1080,
   parameter int unsigned N_PARALLEL     = 2,
   parameter int unsigned HALO           = 3,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  up_end,
   stream_in_dispatch_if.slave   bus,
   output logic                  frame_done,
   output logic                  err_tlast
);
   localparam int unsigned COL_W = clog2_min1(SRC_IMG_WIDTH);
   localparam int unsigned ROW_W = clog2_min1(SRC_IMG_HEIGHT);
   localparam int unsigned FW    = DATA_WIDTH + 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_IMG_HEIGHT - 1);

   state_e              r_state;
   logic [COL_W-1:0]    r_col;
   logic [ROW_W-1:0]    r_row;
   logic                r_frame_done;
   logic                r_err;

   logic [N_PARALLEL-1:0] w_dest;
   logic [N_PARALLEL-1:0] w_tag;
   logic [N_PARALLEL-1:0] w_full;
   logic [N_PARALLEL-1:0] w_empty;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_col_last;
   logic                  w_frame_end;
   logic                  w_col_wrap;
   logic                  w_mismatch;

   assign w_col_last  = (r_col == COL_LAST);
   assign w_frame_end = w_col_last && (r_row == ROW_LAST);

`ifdef STREAM_IN_TLAST_CHECK_EN
   assign w_col_wrap  = w_col_last | bus.s_axis_tlast;
   assign w_mismatch  = bus.s_axis_tlast ^ w_col_last;
`else
   logic w_unused_tlast;
   assign w_unused_tlast = bus.s_axis_tlast;
   assign w_col_wrap     = w_col_last;
   assign w_mismatch     = 1'b0;
`endif

   // Beat stalls only if some PE that needs it has a full channel.
   assign w_ready  = (r_state == ST_RUN) && (&(~w_dest | ~w_full));
   assign w_accept = bus.s_axis_tvalid & w_ready;
   assign bus.s_axis_tready = w_ready;

   assign frame_done = r_frame_done;
   assign err_tlast  = r_err;

   genvar j;
   generate
      for (j = 0; j < N_PARALLEL; j++) begin : g_pe
         localparam int unsigned WS = win_start(j, SRC_IMG_WIDTH, N_PARALLEL, HALO);
         localparam int unsigned WE = win_end(j, SRC_IMG_WIDTH, N_PARALLEL, HALO);
         logic          w_lo_ok;
         logic          w_hi_ok;
         logic [FW-1:0] w_out;

         if (WS == 0) begin : g_lo_open
            assign w_lo_ok = 1'b1;
         end else begin : g_lo_cmp
            assign w_lo_ok = (r_col >= COL_W'(WS));
         end
         if (WE == SRC_IMG_WIDTH - 1) begin : g_hi_open
            assign w_hi_ok = 1'b1;
         end else begin : g_hi_cmp
            assign w_hi_ok = (r_col <= COL_W'(WE));
         end

         assign w_dest[j] = w_lo_ok & w_hi_ok;
         assign w_tag[j]  = (r_col == COL_W'(WE));

         stream_in_dispatch_fifo #(
            .WIDTH (FW),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (up_end),
            .i_push  (w_accept & w_dest[j]),
            .i_data  ({w_tag[j], bus.s_axis_tdata}),
            .i_pop   (bus.m_ready[j]),
            .o_data  (w_out),
            .o_full  (w_full[j]),
            .o_empty (w_empty[j])
         );

         assign bus.m_valid[j]                         = ~w_empty[j];
         assign bus.m_data[j*DATA_WIDTH +: DATA_WIDTH] = w_out[DATA_WIDTH-1:0];
         assign bus.m_last[j]                          = w_out[DATA_WIDTH];
      end
   endgenerate

   // Frame FSM with col/row tracking; up_end wins over start and over an accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_frame_done <= 1'b1;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && !up_end) begin
                  r_state      <= ST_RUN;
                  r_frame_done <= 1'b0;
                  r_col        <= '0;
                  r_row        <= '0;
                  r_err        <= 1'b0;
               end
            end
            ST_RUN: begin
               if (up_end) begin
                  r_state      <= ST_IDLE;
                  r_frame_done <= 1'b1;
                  r_col        <= '0;
                  r_row        <= '0;
               end else if (w_accept) begin
                  if (w_mismatch) r_err <= 1'b1;
                  if (w_frame_end) begin
                     r_state      <= ST_IDLE;
                     r_frame_done <= 1'b1;
                     r_col        <= '0;
                     r_row        <= '0;
                  end else if (w_col_wrap) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_frame_done <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_in_dispatch.sv
// Scoreboard bench for stream_in_dispatch: randomized beats, per-PE expected queues.
module tb_stream_in_dispatch;
   localparam int W = 16, H = 4, N = 2, HALO = 2, DEPTH = 4, DW = 32;
   localparam int B = W / N;
`ifdef STREAM_IN_TLAST_CHECK_EN
   localparam bit TLAST_CHK = 1'b1;
`else
   localparam bit TLAST_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, start, up_end, frame_done, err_tlast;
   always #5 clk = ~clk;

   stream_in_dispatch_if #(.DATA_WIDTH(DW), .N_PARALLEL(N)) sif ();

   stream_in_dispatch #(
      .DATA_WIDTH(DW), .SRC_IMG_WIDTH(W), .SRC_IMG_HEIGHT(H),
      .N_PARALLEL(N), .HALO(HALO), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .up_end(up_end),
      .bus(sif), .frame_done(frame_done), .err_tlast(err_tlast)
   );

   int n_cmp = 0, n_fail = 0;
   logic [DW:0] exp_q [N][$];
   int pops [N];
   int m_col, m_row, n_acc, cyc, a0;
   bit m_run, m_err, vrand, rrand;
   logic [DW:0] mon_e;

   function automatic int win_lo(input int j);
      int lo;
      lo = j * B - HALO;
      return (lo < 0) ? 0 : lo;
   endfunction

   function automatic int win_hi(input int j);
      int hi;
      hi = (j + 1) * B - 1 + HALO;
      return (hi > W - 1) ? W - 1 : hi;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: one accepted pixel fans out to every covering window, then col/row advance.
   task automatic model_beat(input logic [DW-1:0] d, input logic tl);
      for (int j = 0; j < N; j++)
         if (m_col >= win_lo(j) && m_col <= win_hi(j))
            exp_q[j].push_back({(m_col == win_hi(j)), d});
      n_acc++;
      if (TLAST_CHK && (tl != (m_col == W - 1))) m_err = 1'b1;
      if (m_col == W - 1 && m_row == H - 1) begin
         m_run = 1'b0; m_col = 0; m_row = 0;
      end else if (m_col == W - 1 || (TLAST_CHK && tl)) begin
         m_col = 0; m_row++;
      end else begin
         m_col++;
      end
   endtask

   task automatic step();
      logic acc, st, ue, tl;
      logic [DW-1:0] d;
      @(negedge clk);
      chk("frame_done", frame_done, !m_run);
      chk("err_tlast", err_tlast, m_err);
      if (!m_run) chk("tready_idle", sif.s_axis_tready, 0);
      acc = sif.s_axis_tvalid & sif.s_axis_tready;
      st = start; ue = up_end; tl = sif.s_axis_tlast; d = sif.s_axis_tdata;
      @(posedge clk);
      if (ue) begin
         for (int j = 0; j < N; j++) exp_q[j].delete();
         m_run = 1'b0; m_col = 0; m_row = 0;
      end else if (!m_run) begin
         if (st) begin m_run = 1'b1; m_col = 0; m_row = 0; m_err = 1'b0; end
      end else if (acc) begin
         model_beat(d, tl);
      end
      #1;
      if (vrand) sif.s_axis_tvalid = ($urandom_range(3) != 0);
      if (rrand) sif.m_ready = N'($urandom);
      sif.s_axis_tdata = $urandom;
      sif.s_axis_tlast = (m_col == W - 1);
   endtask

   task automatic drain();
      sif.s_axis_tvalid = 1'b0;
      sif.m_ready = '1;
      for (int k = 0; k < 20 && (exp_q[0].size() + exp_q[1].size()) != 0; k++) step();
      step();
      for (int j = 0; j < N; j++) chk($sformatf("drain_pe%0d", j), exp_q[j].size(), 0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_tready", sif.s_axis_tready, 0);
      chk("rst_m_valid", sif.m_valid, 0);
      chk("rst_m_data", sif.m_data, 0);
      chk("rst_m_last", sif.m_last, 0);
      chk("rst_frame_done", frame_done, 1);
      chk("rst_err_tlast", err_tlast, 0);
   endtask

   // Monitor: every PE handshake pops and checks the oldest expected beat for that PE.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            for (int j = 0; j < N; j++) begin
               if (sif.m_valid[j] && sif.m_ready[j]) begin
                  if (exp_q[j].size() == 0) begin
                     n_cmp++; n_fail++;
                     $display("FAIL pe%0d_unexpected: got beat %0h, expected no beat", j,
                              sif.m_data[j*DW +: DW]);
                  end else begin
                     mon_e = exp_q[j].pop_front();
                     chk($sformatf("pe%0d_data", j), sif.m_data[j*DW +: DW], mon_e[DW-1:0]);
                     chk($sformatf("pe%0d_last", j), sif.m_last[j], mon_e[DW]);
                     pops[j]++;
                  end
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; up_end = 1'b0;
      sif.s_axis_tvalid = 1'b0; sif.s_axis_tdata = '0; sif.s_axis_tlast = 1'b0; sif.m_ready = '0;
      m_run = 1'b0; m_err = 1'b0; m_col = 0; m_row = 0; n_acc = 0; vrand = 1'b0; rrand = 1'b0;
      pops[0] = 0; pops[1] = 0;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      @(posedge clk); #1 rst_n = 1'b1;

      // tvalid before start: nothing accepted
      sif.s_axis_tvalid = 1'b1;
      repeat (5) step();
      chk("idle_no_push", sif.m_valid, 0);
      chk("idle_no_accept", n_acc, 0);

      // full frame, all ready
      sif.m_ready = '1; start = 1'b1; step(); start = 1'b0;
      a0 = n_acc; pops[0] = 0; pops[1] = 0; cyc = 0;
      while (m_run && cyc < 200) begin step(); cyc++; end
      chk("frame_beats", n_acc - a0, 64);
      chk("frame_cycles", cyc, 64);
      step();
      drain();
      chk("pe0_count", pops[0], 40);
      chk("pe1_count", pops[1], 40);

      // PE1 backpressure
      sif.m_ready = 2'b01; sif.s_axis_tvalid = 1'b1; start = 1'b1; step(); start = 1'b0;
      repeat (16) step();
      chk("stall_tready", sif.s_axis_tready, 0);
      chk("stall_pe1_fill", exp_q[1].size(), 4);
      chk("stall_accepts", n_acc - a0 - 64, 10);
      sif.m_ready = 2'b11; step();
      chk("resume_tready", sif.s_axis_tready, 1);
      a0 = n_acc; step();
      chk("resume_accept", n_acc - a0, 1);

      // up_end mid-frame with data buffered
      vrand = 1'b1; rrand = 1'b1; cyc = 0;
      while (!(m_row == 2 && m_col == 5) && cyc < 500) begin step(); cyc++; end
      chk("reach_r2c5", m_row * W + m_col, 2 * W + 5);
      vrand = 1'b0; rrand = 1'b0; sif.m_ready = '0; sif.s_axis_tvalid = 1'b1;
      step();
      chk("pre_abort_valid", sif.m_valid[0], 1);
      up_end = 1'b1; step(); up_end = 1'b0;
      chk("abort_m_valid", sif.m_valid, 0);
      chk("abort_tready", sif.s_axis_tready, 0);
      chk("abort_frame_done", frame_done, 1);

      // restart, random traffic, ignored mid-frame start
      start = 1'b1; step(); start = 1'b0; vrand = 1'b1; rrand = 1'b1; cyc = 0;
      while (m_run && cyc < 2000) begin
         step(); cyc++;
         start = (cyc == 30);
      end
      start = 1'b0;
      chk("rand_frame_end", frame_done, 1);
      vrand = 1'b0; rrand = 1'b0;
      drain();

      // tlast injected at row 1, col 12
      sif.m_ready = '1; sif.s_axis_tvalid = 1'b1; start = 1'b1; step(); start = 1'b0; cyc = 0;
      while (!(m_row == 1 && m_col == 12) && cyc < 100) begin step(); cyc++; end
      sif.s_axis_tlast = 1'b1;
      step();
      chk("early_tlast_err", err_tlast, TLAST_CHK);
      cyc = 0;
      while (m_run && cyc < 200) begin step(); cyc++; end
      drain();

      // start and up_end together stay idle
      sif.s_axis_tvalid = 1'b1; start = 1'b1; up_end = 1'b1; step(); start = 1'b0; up_end = 1'b0;
      repeat (3) step();
      chk("su_frame_done", frame_done, 1);
      chk("su_tready", sif.s_axis_tready, 0);

      // new start clears err; then reset mid-frame
      start = 1'b1; step(); start = 1'b0;
      chk("err_cleared", err_tlast, 0);
      repeat (20) step();
      rst_n = 1'b0; #1;
      chk_reset_vals();
      for (int j = 0; j < N; j++) exp_q[j].delete();
      m_run = 1'b0; m_err = 1'b0; m_col = 0; m_row = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
